// File: rtl/hilo_div_pkg.sv
// Shared definitions for the EX-stage HI/LO divider: operation codes, divider FSM
// states, iteration count and the divide-by-zero quotient.
package hilo_div_pkg;

  localparam int unsigned DIV_CYCLES    = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE,
    DIV_WAIT_DROP
  } div_state_t;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_ADDU,
    OP_SUB,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_LUI,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_MTHI,
    OP_MTLO,
    OP_MFHI,
    OP_MFLO
  } oper_t;

  function automatic logic need_write_hilo(input oper_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself read as unsigned.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division iteration: shift the partial remainder left, trial
// subtract the divisor magnitude, keep the difference when it does not borrow.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W:0] part_rem,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W:0]   trial;
  logic [W+1:0] diff;
  logic         borrow;

  always_comb begin
    trial    = part_rem[2*W-1:W-1];
    diff     = {1'b0, trial} - {2'b0, divisor};
    // A set top bit means the shifted value exceeds any divisor, so no borrow.
    borrow   = diff[W+1] & ~part_rem[2*W];
    q_bit    = ~borrow;
    rem_next = borrow ? trial : diff[W:0];
  end

endmodule

// File: rtl/hilo_div.sv
// Iterative 32-bit DIV/DIVU unit feeding HI (remainder) and LO (quotient).
// Optional macro HILO_DIV_EARLY_OUT_EN finishes at once when |dividend| < |divisor|.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [DIV_WIDTH-1:0] dividend_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  input  logic                 cancel_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DIV_WIDTH-1:0] hi_o,
  output logic [DIV_WIDTH-1:0] lo_o,
  output logic                 div_zero_o
);

  localparam int unsigned W = DIV_WIDTH;

  div_state_t   state, state_nxt;
  logic [5:0]   count;
  logic [2*W:0] pr, pr_nxt;
  logic [W-1:0] mag_b;
  logic         neg_q, neg_r;

  logic [W:0]   rem_next;
  logic         q_bit;
  logic [W-1:0] dvd_mag, dvs_mag;
  logic [W-1:0] quot, rem;
  logic         accept, dvs_zero, early_out, last_step;

  assign dvd_mag   = abs_val(dividend_i, signed_i);
  assign dvs_mag   = abs_val(divisor_i, signed_i);
  assign dvs_zero  = (divisor_i == '0);
  assign accept    = (state == DIV_IDLE) && start_i && !cancel_i;
  assign last_step = (state == DIV_BUSY) && (count == 6'(DIV_CYCLES - 1));

`ifdef HILO_DIV_EARLY_OUT_EN
  assign early_out = !dvs_zero && (dvd_mag < dvs_mag);
`else
  assign early_out = 1'b0;
`endif

  div_step #(.W(W)) u_step (
    .part_rem (pr),
    .divisor  (mag_b),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign pr_nxt = {rem_next, pr[W-2:0], q_bit};
  assign quot   = pr_nxt[W-1:0];
  assign rem    = pr_nxt[2*W-1:W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      DIV_IDLE: begin
        busy_o = start_i;
        if (accept) begin
          state_nxt = (dvs_zero || early_out) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        busy_o = 1'b1;
        if (last_step) begin
          state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done_o    = 1'b1;
        state_nxt = DIV_WAIT_DROP;
      end
      DIV_WAIT_DROP: begin
        if (!start_i) begin
          state_nxt = DIV_IDLE;
        end
      end
      default: state_nxt = DIV_IDLE;
    endcase
    if (cancel_i) begin
      state_nxt = DIV_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      pr         <= '0;
      mag_b      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else if (cancel_i) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
      pr    <= {{(W+1){1'b0}}, dvd_mag};
      mag_b <= dvs_mag;
      neg_q <= signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
      neg_r <= signed_i & dividend_i[W-1];
      if (dvs_zero) begin
        lo_o       <= DIV_ZERO_QUOT;
        hi_o       <= dividend_i;
        div_zero_o <= 1'b1;
      end else if (early_out) begin
        lo_o       <= '0;
        hi_o       <= dividend_i;
        div_zero_o <= 1'b0;
      end
    end else if (state == DIV_BUSY) begin
      pr    <= pr_nxt;
      count <= count + 6'd1;
      // Sign fix is folded into the final iteration edge so DONE shows the result.
      if (last_step) begin
        lo_o       <= neg_q ? (~quot + 1'b1) : quot;
        hi_o       <= neg_r ? (~rem + 1'b1) : rem;
        div_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div.sv
// Self-checking bench for hilo_div: directed cases plus random operands checked
// against an arithmetic reference model (latency, HI/LO, div-by-zero flag).
module tb_hilo_div;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        cancel_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_zero_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  hilo_div #(.DIV_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .cancel_i   (cancel_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int unsigned lat);
    longint sa, sb, ma, mb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dz = 1'b1;
      lat = 1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0;
      lat = 33;
`ifdef HILO_DIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`else
      if (ma < mb) lat = 33;
`endif
    end
  endfunction

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned hold);
    logic [31:0] eq, er;
    logic edz;
    int unsigned elat, k, busy_cnt;
    logic seen;
    model(sgn, a, b, eq, er, edz, elat);
    @(negedge clk);
    start_i = 1'b1;
    signed_i = sgn;
    dividend_i = a;
    divisor_i = b;
    #1 check("busy_on_request", 32'(busy_o), 32'd1);
    k = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (k < 60 && !seen) begin
      @(posedge clk);
      #1;
      k++;
      if (done_o) seen = 1'b1;
      else if (busy_o) busy_cnt++;
      // Operands must only matter at accept.
      dividend_i = $urandom;
      divisor_i = $urandom;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", k, elat);
    check("busy_cycles", busy_cnt, elat - 1);
    check("busy_at_done", 32'(busy_o), 32'd0);
    check("lo", lo_o, eq);
    check("hi", hi_o, er);
    check("div_zero", 32'(div_zero_o), 32'(edz));
    last_hi = er;
    last_lo = eq;
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk);
      #1;
      check("no_retrigger_done", 32'(done_o), 32'd0);
      check("no_retrigger_busy", 32'(busy_o), 32'd0);
    end
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("hold_lo", lo_o, eq);
  endtask

  initial begin
    logic [31:0] a, b;
    logic sgn;
    int unsigned cls;

    rst = 1'b0;
    start_i = 1'b0;
    signed_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    cancel_i = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_dz", 32'(div_zero_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(1'b0, 32'd5, 32'd0, 0);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(1'b0, 32'd3, 32'd10, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 3);

    // Cancel at iteration 10, then an immediate new request.
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("cancel_done", 32'(done_o), 32'd0);
    check("cancel_busy", 32'(busy_o), 32'd0);
    check("cancel_hi", hi_o, last_hi);
    check("cancel_lo", lo_o, last_lo);
    cancel_i = 1'b0;
    run_op(1'b0, 32'd1234567, 32'd89, 0);

    // Start together with cancel in IDLE must not be accepted.
    @(negedge clk);
    start_i = 1'b1;
    cancel_i = 1'b1;
    dividend_i = 32'd50;
    divisor_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    cancel_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("cancel_start_busy", 32'(busy_o), 32'd0);
      check("cancel_start_done", 32'(done_o), 32'd0);
    end

    // Reset in the middle of an iteration sequence.
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b1;
    dividend_i = 32'hDEAD_BEEF;
    divisor_i = 32'd17;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_dz", 32'(div_zero_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 32'd81, 32'd9, 0);

    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom);
      cls = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (cls)
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 15); b = $urandom_range(16, 1000); end
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        4: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(sgn, a, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
